// File: rtl/infrarojo_pkg.sv
// Shared encodings for the IR line-follower controller: steering codes, FSM
// states, sensor weights and the helpers that turn a sensor word into a command.
package infrarojo_pkg;

  localparam logic [2:0] DIR_STOP       = 3'd0;
  localparam logic [2:0] DIR_FWD        = 3'd1;
  localparam logic [2:0] DIR_LEFT_SOFT  = 3'd2;
  localparam logic [2:0] DIR_LEFT_HARD  = 3'd3;
  localparam logic [2:0] DIR_RIGHT_SOFT = 3'd4;
  localparam logic [2:0] DIR_RIGHT_HARD = 3'd5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_LOST   = 2'd3;

  localparam logic signed [4:0] W_L  = -5'sd2;
  localparam logic signed [4:0] W_LC = -5'sd1;
  localparam logic signed [4:0] W_C  =  5'sd0;
  localparam logic signed [4:0] W_RC =  5'sd1;
  localparam logic signed [4:0] W_R  =  5'sd2;

  typedef enum logic {SIDE_LEFT = 1'b0, SIDE_RIGHT = 1'b1} side_e;

  // Bit 4 is the leftmost sensor, bit 0 the rightmost.
  function automatic logic signed [4:0] sens_weight(input logic [2:0] idx);
    case (idx)
      3'd4:    return W_L;
      3'd3:    return W_LC;
      3'd2:    return W_C;
      3'd1:    return W_RC;
      default: return W_R;
    endcase
  endfunction

  function automatic logic signed [3:0] sat_pos(input logic signed [4:0] s);
    if (s > 5'sd3)       return 4'sd3;
    else if (s < -5'sd3) return -4'sd3;
    else                 return s[3:0];
  endfunction

  function automatic logic [2:0] map_dir(input logic signed [3:0] pos,
                                         input logic [2:0] cnt);
    if (cnt == 3'd5)      return DIR_FWD;
    if (pos == 4'sd0)     return DIR_FWD;
    if (pos == -4'sd1)    return DIR_LEFT_SOFT;
    if (pos < 4'sd0)      return DIR_LEFT_HARD;
    if (pos == 4'sd1)     return DIR_RIGHT_SOFT;
    return DIR_RIGHT_HARD;
  endfunction

  function automatic logic [2:0] hard_dir(input side_e s);
    return (s == SIDE_LEFT) ? DIR_LEFT_HARD : DIR_RIGHT_HARD;
  endfunction

endpackage

// File: rtl/infrarojo_debounce.sv
// One sensor bit: two-flop synchroniser followed by a tick-sampled debouncer
// that accepts a new level only after DEBOUNCE_N consecutive differing samples.
module infrarojo_debounce #(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic d,
  output logic q
);

  localparam int CW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N + 1) : 1;

  logic          meta_q, sync_q;
  logic          q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (tick) begin
      if (sync_q != q_q) begin
        if (cnt_q == CW'(DEBOUNCE_N - 1)) begin
          q_d   = sync_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      q_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/infrarojo_ctrl.sv
// Line-follower controller: sample prescaler, per-bit debounce, line position
// and the TRACK/SEARCH/LOST steering state machine.
module infrarojo_ctrl
  import infrarojo_pkg::*;
#(
  parameter int SAMPLE_DIV   = 1000,
  parameter int DEBOUNCE_N   = 4,
  parameter int LOST_TIMEOUT = 250,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4:0]        sens_i,
  output logic [4:0]        sens_o,
  output logic              sample_stb,
  output logic signed [3:0] pos_o,
  output logic [2:0]        dir_o,
  output logic [1:0]        state_o,
  output logic              cross_o,
  output logic              lost_o
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT + 1) : 1;

  logic [PW-1:0]     pre_q, pre_d;
  logic              tick, dec_q;
  logic [4:0]        deb;
  logic signed [4:0] sum;
  logic [2:0]        cnt;
  logic signed [3:0] pos;

  logic [1:0]        state_q, state_d;
  logic [2:0]        dir_q, dir_d;
  logic [4:0]        sens_q, sens_d;
  logic signed [3:0] pos_q, pos_d;
  logic              cross_q, cross_d, lost_q, lost_d, stb_q, stb_d, track;
  side_e             side_q, side_d;
  logic [SW-1:0]     srch_q, srch_d, srch_inc;

  assign tick = en && (pre_q == PW'(SAMPLE_DIV - 1));

  always_comb begin
    pre_d = pre_q + 1'b1;
    if (!en || tick) pre_d = '0;
  end

  // Polarity fix is a constant inversion at the pin, ahead of the synchroniser.
  for (genvar i = 0; i < 5; i++) begin : g_bit
    infrarojo_debounce #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .d    (sens_i[i] ^ ACTIVE_LOW),
      .q    (deb[i])
    );
  end

  always_comb begin
    sum = '0;
    cnt = '0;
    for (int i = 0; i < 5; i++) begin
      if (deb[i]) begin
        sum = sum + sens_weight(3'(i));
        cnt = cnt + 3'd1;
      end
    end
    pos = sat_pos(sum);
  end

  assign srch_inc = (srch_q == SW'(LOST_TIMEOUT)) ? srch_q : srch_q + 1'b1;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    sens_d  = sens_q;
    pos_d   = pos_q;
    cross_d = cross_q;
    lost_d  = lost_q;
    side_d  = side_q;
    srch_d  = srch_q;
    stb_d   = 1'b0;
    track   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      dir_d   = DIR_STOP;
      lost_d  = 1'b0;
    end else if (dec_q) begin
      stb_d   = 1'b1;
      sens_d  = deb;
      pos_d   = pos;
      cross_d = (cnt == 3'd5);
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TRACK;
          dir_d   = DIR_STOP;
        end
        ST_TRACK: begin
          if (cnt != 3'd0) track = 1'b1;
          else begin
            state_d = ST_SEARCH;
            srch_d  = '0;
            dir_d   = hard_dir(side_q);
          end
        end
        ST_SEARCH: begin
          if (cnt != 3'd0) track = 1'b1;
          else begin
            dir_d  = hard_dir(side_q);
            srch_d = srch_inc;
            if (srch_inc == SW'(LOST_TIMEOUT)) begin
              state_d = ST_LOST;
              dir_d   = DIR_STOP;
              lost_d  = 1'b1;
            end
          end
        end
        default: begin
          if (cnt != 3'd0) track = 1'b1;
          else dir_d = DIR_STOP;
        end
      endcase
      if (track) begin
        state_d = ST_TRACK;
        lost_d  = 1'b0;
        dir_d   = map_dir(pos, cnt);
        if (pos < 4'sd0)      side_d = SIDE_LEFT;
        else if (pos > 4'sd0) side_d = SIDE_RIGHT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      dec_q   <= 1'b0;
      state_q <= ST_IDLE;
      dir_q   <= DIR_STOP;
      sens_q  <= '0;
      pos_q   <= '0;
      cross_q <= 1'b0;
      lost_q  <= 1'b0;
      side_q  <= SIDE_LEFT;
      srch_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      dec_q   <= tick;
      state_q <= state_d;
      dir_q   <= dir_d;
      sens_q  <= sens_d;
      pos_q   <= pos_d;
      cross_q <= cross_d;
      lost_q  <= lost_d;
      side_q  <= side_d;
      srch_q  <= srch_d;
      stb_q   <= stb_d;
    end
  end

  assign sens_o     = sens_q;
  assign sample_stb = stb_q;
  assign pos_o      = pos_q;
  assign dir_o      = dir_q;
  assign state_o    = state_q;
  assign cross_o    = cross_q;
  assign lost_o     = lost_q;

endmodule

// File: tb/tb_infrarojo_ctrl.sv
// Directed bench for infrarojo_ctrl with SAMPLE_DIV=4, DEBOUNCE_N=2, LOST_TIMEOUT=3.
module tb_infrarojo_ctrl;

  localparam int D_STOP = 0, D_FWD = 1, D_LSOFT = 2, D_LHARD = 3, D_RSOFT = 4, D_RHARD = 5;
  localparam int S_IDLE = 0, S_TRACK = 1, S_SEARCH = 2, S_LOST = 3;

  logic              clk, rst, en;
  logic [4:0]        sens_i, sens_o;
  logic              sample_stb, cross_o, lost_o;
  logic signed [3:0] pos_o;
  logic [2:0]        dir_o;
  logic [1:0]        state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int c;

  infrarojo_ctrl #(
    .SAMPLE_DIV   (4),
    .DEBOUNCE_N   (2),
    .LOST_TIMEOUT (3),
    .ACTIVE_LOW   (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sens_i     (sens_i),
    .sens_o     (sens_o),
    .sample_stb (sample_stb),
    .pos_o      (pos_o),
    .dir_o      (dir_o),
    .state_o    (state_o),
    .cross_o    (cross_o),
    .lost_o     (lost_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns the number of clocks until the next strobe, sampled 1 time unit after the edge.
  task automatic wait_stb(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!sample_stb && cyc < 40);
    chk("stb_seen", int'(sample_stb), 1);
  endtask

  task automatic apply(input logic [4:0] p);
    int k;
    sens_i = p;
    wait_stb(k);
    wait_stb(k);
  endtask

  task automatic chk_out(input string tag, input int s, input int p, input int d,
                         input int st, input int cr, input int lo);
    chk({tag, "_sens"},  int'(sens_o), s);
    chk({tag, "_pos"},   int'($signed(pos_o)), p);
    chk({tag, "_dir"},   int'(dir_o), d);
    chk({tag, "_state"}, int'(state_o), st);
    chk({tag, "_cross"}, int'(cross_o), cr);
    chk({tag, "_lost"},  int'(lost_o), lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; sens_i = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 0, 0, D_STOP, S_IDLE, 0, 0);
    chk("rst_stb", int'(sample_stb), 0);

    // 1: enable with centre sensor
    rst = 1'b0; en = 1'b1; sens_i = 5'b00100;
    wait_stb(c);
    chk("t1_first_lat", c, 5);
    chk_out("t1_d1", 0, 0, D_STOP, S_TRACK, 0, 0);
    wait_stb(c);
    chk("t1_period", c, 4);
    chk_out("t1_d2", 5'b00100, 0, D_FWD, S_TRACK, 0, 0);
    wait_stb(c);
    chk("t1_period2", c, 4);

    // 2: one-tick glitch must be filtered
    sens_i = 5'b00001;
    wait_stb(c);
    sens_i = 5'b00100;
    chk_out("t2_a", 5'b00100, 0, D_FWD, S_TRACK, 0, 0);
    wait_stb(c);
    chk_out("t2_b", 5'b00100, 0, D_FWD, S_TRACK, 0, 0);
    wait_stb(c);
    chk_out("t2_c", 5'b00100, 0, D_FWD, S_TRACK, 0, 0);

    // 3: steering
    apply(5'b01100); chk_out("t3_lsoft", 5'b01100, -1, D_LSOFT, S_TRACK, 0, 0);
    apply(5'b11000); chk_out("t3_lhard", 5'b11000, -3, D_LHARD, S_TRACK, 0, 0);
    apply(5'b00110); chk_out("t3_rsoft", 5'b00110,  1, D_RSOFT, S_TRACK, 0, 0);
    apply(5'b11111); chk_out("t3_cross", 5'b11111,  0, D_FWD,   S_TRACK, 1, 0);
    apply(5'b00011); chk_out("t3_rhard", 5'b00011,  3, D_RHARD, S_TRACK, 0, 0);

    // 4: loss on the right side, timeout, recovery
    sens_i = 5'b00000;
    wait_stb(c); chk_out("t4_hold",  5'b00011, 3, D_RHARD, S_TRACK, 0, 0);
    wait_stb(c); chk_out("t4_srch0", 0, 0, D_RHARD, S_SEARCH, 0, 0);
    wait_stb(c); chk_out("t4_srch1", 0, 0, D_RHARD, S_SEARCH, 0, 0);
    wait_stb(c); chk_out("t4_srch2", 0, 0, D_RHARD, S_SEARCH, 0, 0);
    wait_stb(c); chk_out("t4_lost",  0, 0, D_STOP,  S_LOST,   0, 1);
    sens_i = 5'b00100;
    wait_stb(c); chk_out("t4_still", 0, 0, D_STOP,  S_LOST,   0, 1);
    wait_stb(c); chk_out("t4_recov", 5'b00100, 0, D_FWD, S_TRACK, 0, 0);

    // 5: left loss recovered inside SEARCH
    apply(5'b11000); chk_out("t5_lhard", 5'b11000, -3, D_LHARD, S_TRACK, 0, 0);
    apply(5'b00000); chk_out("t5_srch0", 0, 0, D_LHARD, S_SEARCH, 0, 0);
    sens_i = 5'b10000;
    wait_stb(c); chk_out("t5_srch1", 0, 0, D_LHARD, S_SEARCH, 0, 0);
    wait_stb(c); chk_out("t5_recov", 5'b10000, -2, D_LHARD, S_TRACK, 0, 0);

    // 6: en drop colliding with a pending decision, then mid-prescale reset
    apply(5'b00000); chk_out("t6_srch", 0, 0, D_LHARD, S_SEARCH, 0, 0);
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1;
    chk_out("t6_idle", 0, 0, D_STOP, S_IDLE, 0, 0);
    chk("t6_no_stb", int'(sample_stb), 0);
    en = 1'b1; sens_i = 5'b11111;
    wait_stb(c);
    chk("t6_restart_lat", c, 5);
    chk_out("t6_exit", 0, 0, D_STOP, S_TRACK, 0, 0);
    wait_stb(c);
    chk_out("t6_cross", 5'b11111, 0, D_FWD, S_TRACK, 1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_out("t6_rst", 0, 0, D_STOP, S_IDLE, 0, 0);
    chk("t6_rst_stb", int'(sample_stb), 0);
    rst = 1'b0;
    wait_stb(c);
    chk("t6_post_rst_lat", c, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
